// File: rtl/astra_pifo_pkg.sv
// ============================================================================
// Module  : astra_pifo_pkg
// Brief   : Shared constants and helpers for the N-ary PIFO tree node.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package astra_pifo_pkg;

  // Comparison keys are widened to this width, so PTW and CTW must be <= 32.
  localparam int unsigned C_KEY_W     = 32;
  localparam int unsigned C_MAX_RADIX = 8;

  function automatic int unsigned data_width(input int unsigned ptw, input int unsigned mtw);
    return ptw + mtw;
  endfunction

  function automatic int unsigned cap_of(input int unsigned ctw);
    return (32'd1 << ctw) - 32'd1;
  endfunction

  function automatic logic prio_better(input logic [C_KEY_W-1:0] a,
                                       input logic [C_KEY_W-1:0] b,
                                       input logic               max_first);
    return max_first ? (a > b) : (a < b);
  endfunction

  function automatic logic [C_MAX_RADIX-1:0] onehot_idx(input logic [2:0] idx);
    return {{(C_MAX_RADIX-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/astra_pifo_sel.sv
// ============================================================================
// Module  : astra_pifo_sel
// Brief   : RADIX-way best-key selector over a validity mask, lowest index on tie.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module astra_pifo_sel
  import astra_pifo_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned RADIX     = 4,
  parameter bit          MAX_FIRST = 1'b0
) (
  input  logic [RADIX*W-1:0] i_keys,
  input  logic [RADIX-1:0]   i_mask,
  output logic [2:0]         o_idx,
  output logic               o_found
);

  logic [C_KEY_W-1:0] w_best_key;

  // A later entry only replaces the current pick when strictly better.
  always_comb begin
    o_idx      = '0;
    o_found    = 1'b0;
    w_best_key = '0;
    for (int c = 0; c < RADIX; c++) begin
      if (i_mask[c] &&
          (!o_found || prio_better(C_KEY_W'(i_keys[c*W +: W]), w_best_key, MAX_FIRST))) begin
        o_found    = 1'b1;
        o_idx      = 3'(c);
        w_best_key = C_KEY_W'(i_keys[c*W +: W]);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/astra_pifo_node_nary.sv
// ============================================================================
// Module  : astra_pifo_node_nary
// Brief   : N-ary PIFO tree node: one head register plus per-child occupancy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module astra_pifo_node_nary
  import astra_pifo_pkg::*;
#(
  parameter int unsigned PTW       = 16,
  parameter int unsigned MTW       = 32,
  parameter int unsigned CTW       = 10,
  parameter int unsigned RADIX     = 4,
  parameter bit          MAX_FIRST = 1'b0,
  parameter bit          LEAF      = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_arst,
  input  logic                       i_push,
  input  logic [MTW+PTW-1:0]         i_push_data,
  input  logic                       i_pop,
  output logic [MTW+PTW-1:0]         o_pop_data,
  output logic                       o_valid,
  output logic                       o_ready,
  output logic                       o_full,
  output logic                       o_drop,
  output logic [RADIX-1:0]           o_push,
  output logic [MTW+PTW-1:0]         o_push_data,
  output logic [RADIX-1:0]           o_pop,
  input  logic [RADIX*(MTW+PTW)-1:0] i_child_data
);

  localparam int unsigned    C_DW  = data_width(PTW, MTW);
  localparam logic [CTW-1:0] C_CAP = CTW'(cap_of(CTW));

  logic [C_DW-1:0]  r_head;
  logic             r_head_valid;
  logic [CTW-1:0]   r_cnt [RADIX];
  logic             r_ready;
  logic             r_busy;
  logic             r_drop;
  logic [RADIX-1:0] r_push;
  logic [RADIX-1:0] r_pop;
  logic [C_DW-1:0]  r_push_data;

  logic [RADIX*PTW-1:0] w_child_prio;
  logic [RADIX*CTW-1:0] w_cnt_flat;
  logic [RADIX-1:0]     w_nonempty;
  logic [RADIX-1:0]     w_room;
  logic [2:0]           w_best_idx;
  logic                 w_any;
  logic [2:0]           w_tgt_idx;
  logic                 w_tgt_found;
  logic [C_DW-1:0]      w_best_data;
  logic                 w_full;
  logic                 w_ready;
  logic                 w_acc_push;
  logic                 w_acc_pop;
  logic                 w_drop;
  logic                 w_in_beats_head;
  logic                 w_child_beats_in;
  logic [RADIX-1:0]     w_best_oh;
  logic [RADIX-1:0]     w_tgt_oh;

  logic [C_DW-1:0]  w_head_n;
  logic             w_valid_n;
  logic [RADIX-1:0] w_push_n;
  logic [RADIX-1:0] w_pop_n;
  logic [C_DW-1:0]  w_push_data_n;
  logic [RADIX-1:0] w_inc;
  logic [RADIX-1:0] w_dec;

  // A leaf has no usable children, so its full flag reduces to head_valid.
  for (genvar c = 0; c < RADIX; c++) begin : g_child
    assign w_child_prio[c*PTW +: PTW] = i_child_data[c*C_DW +: PTW];
    assign w_cnt_flat[c*CTW +: CTW]   = r_cnt[c];
    assign w_nonempty[c]              = !LEAF && (r_cnt[c] != '0);
    assign w_room[c]                  = !LEAF && (r_cnt[c] != C_CAP);
  end

  astra_pifo_sel #(.W(PTW), .RADIX(RADIX), .MAX_FIRST(MAX_FIRST)) u_best (
    .i_keys (w_child_prio),
    .i_mask (w_nonempty),
    .o_idx  (w_best_idx),
    .o_found(w_any)
  );

  astra_pifo_sel #(.W(CTW), .RADIX(RADIX), .MAX_FIRST(1'b0)) u_target (
    .i_keys (w_cnt_flat),
    .i_mask (w_room),
    .o_idx  (w_tgt_idx),
    .o_found(w_tgt_found)
  );

  always_comb begin
    w_best_data = '0;
    for (int c = 0; c < RADIX; c++)
      if (w_best_idx == 3'(c)) w_best_data = i_child_data[c*C_DW +: C_DW];
  end

  assign w_best_oh        = RADIX'(onehot_idx(w_best_idx));
  assign w_tgt_oh         = RADIX'(onehot_idx(w_tgt_idx));
  assign w_full           = r_head_valid && (&(~w_room));
  assign w_ready          = r_ready && !r_busy;
  assign w_acc_push       = w_ready && i_push && !w_full;
  assign w_acc_pop        = w_ready && i_pop && r_head_valid;
  assign w_drop           = w_ready ? ((i_pop && !r_head_valid) || (i_push && w_full))
                                    : (i_push || i_pop);
  assign w_in_beats_head  = prio_better(C_KEY_W'(i_push_data[PTW-1:0]),
                                        C_KEY_W'(r_head[PTW-1:0]), MAX_FIRST);
  assign w_child_beats_in = prio_better(C_KEY_W'(w_best_data[PTW-1:0]),
                                        C_KEY_W'(i_push_data[PTW-1:0]), MAX_FIRST);

  always_comb begin
    w_head_n      = r_head;
    w_valid_n     = r_head_valid;
    w_push_n      = '0;
    w_pop_n       = '0;
    w_push_data_n = '0;
    w_inc         = '0;
    w_dec         = '0;
    if (w_acc_push && w_acc_pop) begin
      // Swap with the best child: its count stays the same.
      if (w_any && w_child_beats_in) begin
        w_head_n      = w_best_data;
        w_push_n      = w_best_oh;
        w_pop_n       = w_best_oh;
        w_push_data_n = i_push_data;
      end else begin
        w_head_n = i_push_data;
      end
    end else if (w_acc_push) begin
      if (!r_head_valid) begin
        w_head_n  = i_push_data;
        w_valid_n = 1'b1;
      end else if (w_tgt_found) begin
        w_push_n      = w_tgt_oh;
        w_inc         = w_tgt_oh;
        w_head_n      = w_in_beats_head ? i_push_data : r_head;
        w_push_data_n = w_in_beats_head ? r_head : i_push_data;
      end
    end else if (w_acc_pop) begin
      if (w_any) begin
        w_head_n = w_best_data;
        w_pop_n  = w_best_oh;
        w_dec    = w_best_oh;
      end else begin
        w_valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_head       <= '0;
      r_head_valid <= 1'b0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_drop       <= 1'b0;
      r_push       <= '0;
      r_pop        <= '0;
      r_push_data  <= '0;
      for (int c = 0; c < RADIX; c++) r_cnt[c] <= '0;
    end else begin
      r_head       <= w_head_n;
      r_head_valid <= w_valid_n;
      r_ready      <= 1'b1;
      r_busy       <= (|w_push_n) || (|w_pop_n);
      r_drop       <= w_drop;
      r_push       <= w_push_n;
      r_pop        <= w_pop_n;
      r_push_data  <= w_push_data_n;
      for (int c = 0; c < RADIX; c++) begin
        if (w_inc[c])      r_cnt[c] <= r_cnt[c] + 1'b1;
        else if (w_dec[c]) r_cnt[c] <= r_cnt[c] - 1'b1;
      end
    end
  end

  assign o_pop_data  = r_head;
  assign o_valid     = r_head_valid;
  assign o_ready     = w_ready;
  assign o_full      = w_full;
  assign o_drop      = r_drop;
  assign o_push      = r_push;
  assign o_push_data = r_push_data;
  assign o_pop       = r_pop;

endmodule

`default_nettype wire
